// File: rtl/apb_guard_pkg.sv
// apb_guard_pkg: shared state encoding and default sizing for the APB timeout guard
package apb_guard_pkg;
    typedef enum logic [1:0] {IDLE, FWD, BLOCK, ABORT} guard_state_e;
    localparam int TIMEOUT_W_DEF = 8;
endpackage

// File: rtl/apb_guard_timer.sv
// apb_guard_timer: clearable access-phase wait counter with terminal-count flag
module apb_guard_timer #(
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);
    logic [TIMEOUT_W-1:0] count;
    assign tc = count == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!reset_n || clr)
            count <= '0;
        else if (inc)
            count <= count + TIMEOUT_W'(1);
    end
endmodule

// File: rtl/apb_timeout_guard.sv
// apb_timeout_guard: zero-latency APB pass-through with wait timeout and fault isolation; optional irq_timeout via APB_GUARD_IRQ_EN
module apb_timeout_guard
    import apb_guard_pkg::*;
#(
    parameter int APB_AW         = 32,
    parameter int APB_DW         = 32,
    parameter int TIMEOUT_W      = TIMEOUT_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [APB_AW-1:0]   APB_S_PADDR,
    input  logic [APB_DW-1:0]   APB_S_PWDATA,
    input  logic                APB_S_PWRITE,
    input  logic [APB_DW/8-1:0] APB_S_PSTRB,
    input  logic                APB_S_PSEL,
    input  logic                APB_S_PENABLE,
    output logic [APB_DW-1:0]   APB_S_PRDATA,
    output logic                APB_S_PREADY,
    output logic                APB_S_PSLVERR,
    output logic [APB_AW-1:0]   APB_M_PADDR,
    output logic [APB_DW-1:0]   APB_M_PWDATA,
    output logic                APB_M_PWRITE,
    output logic [APB_DW/8-1:0] APB_M_PSTRB,
    output logic                APB_M_PSEL,
    output logic                APB_M_PENABLE,
    input  logic [APB_DW-1:0]   APB_M_PRDATA,
    input  logic                APB_M_PREADY,
    input  logic                APB_M_PSLVERR,
    input  logic                ss_en,
`ifdef APB_GUARD_IRQ_EN
    output logic                irq_timeout,
`endif
    output logic                ss_fault
);
    guard_state_e state, next;
    logic allow, stall, tc, m_psel, m_pen, s_ready, s_err;
    logic [APB_DW-1:0] s_rdata;

    assign allow = ss_en && !ss_fault;
    assign stall = state == FWD && APB_S_PSEL && APB_S_PENABLE && !APB_M_PREADY;

    apb_guard_timer #(.TIMEOUT_W(TIMEOUT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk(clk), .reset_n(reset_n), .clr(state != FWD), .inc(stall), .tc(tc)
    );

    always_comb begin
        next    = state;
        m_psel  = 1'b0;
        m_pen   = 1'b0;
        s_ready = 1'b0;
        s_err   = 1'b0;
        s_rdata = '0;
        case (state)
            IDLE: begin
                m_psel = APB_S_PSEL && allow;
                next   = !APB_S_PSEL ? IDLE : allow ? FWD : BLOCK;
            end
            FWD: begin
                m_psel  = APB_S_PSEL;
                m_pen   = APB_S_PSEL && APB_S_PENABLE;
                s_ready = APB_S_PSEL && APB_M_PREADY;
                s_err   = APB_S_PSEL && APB_M_PSLVERR;
                s_rdata = APB_S_PSEL ? APB_M_PRDATA : '0;
                next    = (!APB_S_PSEL || (APB_S_PENABLE && APB_M_PREADY)) ? IDLE :
                          (stall && tc) ? ABORT : FWD;
            end
            BLOCK: begin
                s_ready = APB_S_PSEL && APB_S_PENABLE;
                s_err   = APB_S_PSEL && APB_S_PENABLE;
                next    = (!APB_S_PSEL || APB_S_PENABLE) ? IDLE : BLOCK;
            end
            default: begin
                s_ready = APB_S_PSEL;
                s_err   = APB_S_PSEL;
                next    = IDLE;
            end
        endcase
    end

    // Request payload is always visible downstream; only PSEL/PENABLE qualify it.
    assign APB_M_PADDR   = APB_S_PADDR;
    assign APB_M_PWDATA  = APB_S_PWDATA;
    assign APB_M_PWRITE  = APB_S_PWRITE;
    assign APB_M_PSTRB   = APB_S_PSTRB;
    assign APB_M_PSEL    = reset_n && m_psel;
    assign APB_M_PENABLE = reset_n && m_pen;
    assign APB_S_PREADY  = reset_n && s_ready;
    assign APB_S_PSLVERR = s_err;
    assign APB_S_PRDATA  = s_rdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            ss_fault <= 1'b0;
        end else begin
            state <= next;
            if (state == FWD && next == ABORT)
                ss_fault <= 1'b1;
            else if (state == IDLE && !ss_en)
                ss_fault <= 1'b0;
        end
    end

`ifdef APB_GUARD_IRQ_EN
    logic fault_d;
    always_ff @(posedge clk) fault_d <= reset_n && ss_fault;
    assign irq_timeout = fault_d && ss_fault;
`endif
endmodule

// File: tb/tb_apb_timeout_guard.sv
// tb_apb_timeout_guard: directed plus randomized transfers checked against a per-transfer outcome model
module tb_apb_timeout_guard;
    import apb_guard_pkg::*;
    localparam int T = 4;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [31:0] s_paddr = '0, s_pwdata = '0, s_prdata, m_paddr, m_pwdata, m_prdata = '0;
    logic        s_pwrite = 1'b0, s_psel = 1'b0, s_penable = 1'b0, s_pready, s_pslverr;
    logic [3:0]  s_pstrb = '0, m_pstrb;
    logic        m_pwrite, m_psel, m_penable, m_pready = 1'b0, m_pslverr = 1'b0;
    logic        ss_en = 1'b1, ss_fault;
`ifdef APB_GUARD_IRQ_EN
    logic        irq_timeout;
`endif

    int tests = 0, fails = 0;
    bit fault_m = 1'b0;

    always #5 clk = ~clk;

    apb_timeout_guard #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n),
        .APB_S_PADDR(s_paddr), .APB_S_PWDATA(s_pwdata), .APB_S_PWRITE(s_pwrite),
        .APB_S_PSTRB(s_pstrb), .APB_S_PSEL(s_psel), .APB_S_PENABLE(s_penable),
        .APB_S_PRDATA(s_prdata), .APB_S_PREADY(s_pready), .APB_S_PSLVERR(s_pslverr),
        .APB_M_PADDR(m_paddr), .APB_M_PWDATA(m_pwdata), .APB_M_PWRITE(m_pwrite),
        .APB_M_PSTRB(m_pstrb), .APB_M_PSEL(m_psel), .APB_M_PENABLE(m_penable),
        .APB_M_PRDATA(m_prdata), .APB_M_PREADY(m_pready), .APB_M_PSLVERR(m_pslverr),
        .ss_en(ss_en),
`ifdef APB_GUARD_IRQ_EN
        .irq_timeout(irq_timeout),
`endif
        .ss_fault(ss_fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            edge_drive();
            s_psel = 1'b0; s_penable = 1'b0; m_pready = 1'b0;
            if (!ss_en) fault_m = 1'b0;
            @(negedge clk);
            chk("idle_pready", s_pready, 1'b0);
            chk("idle_fault", ss_fault, fault_m);
        end
    endtask

    // Outcome model: blocked -> error on access cycle 1; forwarded with w waits ->
    // completes on cycle w+1 if w < T, else error on cycle T+1 and fault becomes sticky.
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input bit serr);
        bit allow, done;
        int exp_cycles, k;
        edge_drive();
        if (!ss_en) fault_m = 1'b0;
        allow = ss_en && !fault_m;
        s_paddr = addr; s_pwrite = wr; s_pwdata = wdata; s_pstrb = 4'hF;
        s_psel = 1'b1; s_penable = 1'b0; m_pready = 1'b0;
        @(negedge clk);
        chk("setup_mpsel", m_psel, allow);
        chk("setup_paddr", m_paddr, addr);
        chk("setup_pwrite", m_pwrite, wr);
        exp_cycles = !allow ? 1 : (waits < T ? waits + 1 : T + 1);
        done = 1'b0;
        k = 0;
        while (!done && k < T + 3) begin
            k++;
            edge_drive();
            s_penable = 1'b1;
            m_pready = allow && (k == waits + 1);
            m_prdata = rdata; m_pslverr = serr;
            @(negedge clk);
            if (k == exp_cycles) begin
                done = 1'b1;
                chk("end_pready", s_pready, 1'b1);
                if (allow && waits < T) begin
                    chk("fwd_pslverr", s_pslverr, serr);
                    chk("fwd_prdata", s_prdata, wr ? s_prdata : rdata);
                    chk("fwd_mpsel", m_psel, 1'b1);
                end else begin
                    chk("err_pslverr", s_pslverr, 1'b1);
                    chk("err_prdata", s_prdata, 32'h0);
                    chk("err_mpsel", m_psel, 1'b0);
                    if (allow) fault_m = 1'b1;
`ifdef APB_GUARD_IRQ_EN
                    if (allow) chk("irq_not_yet", irq_timeout, 1'b0);
`endif
                end
                chk("end_fault", ss_fault, fault_m);
            end else begin
                chk("wait_pready", s_pready, 1'b0);
                chk("wait_mpsel", m_psel, allow);
                chk("wait_mpenable", m_penable, allow);
            end
        end
        if (!done) chk("xfer_timeout", k, exp_cycles);
        edge_drive();
        s_psel = 1'b0; s_penable = 1'b0; m_pready = 1'b0;
        @(negedge clk);
        chk("post_pready", s_pready, 1'b0);
        chk("post_mpsel", m_psel, 1'b0);
    endtask

    initial begin
        s_psel = 1'b1;
        @(negedge clk);
        chk("rst_mpsel", m_psel, 1'b0);
        chk("rst_pready", s_pready, 1'b0);
        edge_drive();
        reset_n = 1'b1; s_psel = 1'b0;
        @(negedge clk);
        chk("rst_fault", ss_fault, 1'b0);
        chk("rst_state", dut.state, IDLE);
        idle(1);

        xfer(32'h0103_0004, 1'b0, 32'h0, 2, 32'hA5A5_0001, 1'b0);
        xfer(32'h0103_0008, 1'b0, 32'h0, 0, 32'h0000_BEEF, 1'b1);
        xfer(32'h0103_0010, 1'b0, 32'h0, T - 1, 32'h1111_2222, 1'b0);
        xfer(32'h0103_000C, 1'b0, 32'h0, T, 32'hDEAD_0000, 1'b0);
`ifdef APB_GUARD_IRQ_EN
        chk("irq_rise", irq_timeout, 1'b1);
`endif
        xfer(32'h0000_1234, 1'b1, 32'h55, 0, 32'h0, 1'b0);
        ss_en = 1'b0;
        idle(1);
        chk("fault_clear", ss_fault, 1'b0);
`ifdef APB_GUARD_IRQ_EN
        chk("irq_fall", irq_timeout, 1'b0);
`endif
        xfer(32'h0000_2000, 1'b1, 32'h77, 0, 32'h0, 1'b0);
        ss_en = 1'b1;
        idle(1);

        edge_drive();
        s_paddr = 32'h0103_0020; s_psel = 1'b1; s_penable = 1'b0; m_pready = 1'b0;
        edge_drive();
        s_penable = 1'b1;
        edge_drive();
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_mpsel", m_psel, 1'b0);
        chk("midrst_mpenable", m_penable, 1'b0);
        chk("midrst_pready", s_pready, 1'b0);
        edge_drive();
        reset_n = 1'b1; s_psel = 1'b0; s_penable = 1'b0;
        @(negedge clk);
        chk("midrst_state", dut.state, IDLE);
        chk("midrst_fault", ss_fault, 1'b0);
        chk("midrst_count", dut.u_timer.count, 0);
        fault_m = 1'b0;
        idle(1);

        for (int n = 0; n < 30; n++) begin
            ss_en = ($urandom_range(3) != 0);
            idle($urandom_range(2));
            xfer($urandom, 1'($urandom_range(1)), $urandom, $urandom_range(T + 1),
                 $urandom, 1'($urandom_range(1)));
        end
        idle(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/apb_timeout_guard.md
# apb_timeout_guard

Per-port APB protection stage placed between one APB manager port of the peripheral OBI interconnect and the student subsystem it addresses. It forwards APB transfers with zero added latency, terminates any access phase the subsystem holds beyond a programmed number of wait cycles with PSLVERR, and isolates a subsystem that is disabled or has faulted. This stops a hung or absent student design from stalling the shared OBI bus.

## Interface
- APB_AW, 32, address width
- APB_DW, 32, data width; strobe width APB_DW/8
- TIMEOUT_W, 8, width of wait-cycle counter
- TIMEOUT_CYCLES, 255, maximum access-phase wait cycles; legal range 1..2^TIMEOUT_W-1
- clk  in  1  clock
- reset_n  in  1  reset; one clock, synchronous, active-low
- APB_S_PADDR / PWDATA / PWRITE / PSTRB / PSEL / PENABLE  in  APB_AW / APB_DW / 1 / APB_DW/8 / 1 / 1  upstream request from interconnect
- APB_S_PRDATA / PREADY / PSLVERR  out  APB_DW / 1 / 1  upstream response
- APB_M_PADDR / PWDATA / PWRITE / PSTRB / PSEL / PENABLE  out  as upstream  request to subsystem
- APB_M_PRDATA / PREADY / PSLVERR  in  APB_DW / 1 / 1  subsystem response
- ss_en  in  1  subsystem enable (one bit of the SS_Ctrl word)
- ss_fault  out  1  sticky timeout flag; reset 0
- irq_timeout  out  1  present only with APB_GUARD_IRQ_EN

## Operation
- States: IDLE, FWD, BLOCK, ABORT. Reset → IDLE; counter 0; ss_fault 0.
- IDLE, S_PSEL=1 (setup phase): if ss_en=1 and ss_fault=0 → FWD, else → BLOCK. Decision combinational in setup cycle; registered state from next cycle.
- FWD: M_PADDR/PWDATA/PWRITE/PSTRB pass through; M_PSEL=S_PSEL; M_PENABLE=S_PENABLE; S_PRDATA/PREADY/PSLVERR = M_ counterparts, same cycle. Setup cycle in IDLE also drives M_PSEL when forwarding is allowed.
- Counter: cleared in IDLE; +1 per access cycle (S_PENABLE=1) with M_PREADY=0. M_PREADY=1 → transfer ends, → IDLE.
- Counter == TIMEOUT_CYCLES-1 with M_PREADY=0 → ABORT; ss_fault set.
- ABORT (one cycle): M_PSEL=0, M_PENABLE=0; S_PREADY=1, S_PSLVERR=1, S_PRDATA=0; → IDLE. Late M_PREADY in this cycle ignored.
- BLOCK: M_PSEL=0; in access phase S_PREADY=1, S_PSLVERR=1, S_PRDATA=0 (zero wait states); → IDLE.
- ss_fault clears only when ss_en=0 is sampled in IDLE.
- ss_en change during FWD has no effect on the in-flight transfer.
- S_PSEL=0: S_PREADY=0, S_PSLVERR=0, S_PRDATA=0; M_PSEL=0, M_PENABLE=0.

## Timing
- Forwarded path: purely combinational, 0 cycles added.
- Blocked transfer: setup + 1 access cycle (2 cycles total).
- Timeout: subsystem stalls access cycles 1..TIMEOUT_CYCLES; error completion on access cycle TIMEOUT_CYCLES+1.
- Back-to-back transfers: IDLE accepts a new setup in the cycle after completion.
- reset_n low: M_PSEL and M_PENABLE forced 0 and S_PREADY forced 0 in the same cycle; state IDLE at the next edge.

## Configuration
- APB_GUARD_IRQ_EN defined: irq_timeout port exists; asserts one cycle after ss_fault sets; stays high until ss_fault clears. Reset 0.
- Undefined: port absent; ss_fault behaviour unchanged.

## Structure
- apb_guard_pkg: guard_state_e enum (IDLE, FWD, BLOCK, ABORT); TIMEOUT_W default constant.
- Sub-module apb_guard_timer: clearable wait counter with terminal-count output, parameterized by TIMEOUT_W and TIMEOUT_CYCLES.
- Guard FSM and response mux stay in the top module.

## Test plan
- ss_en=1, read 0x0103_0004, M_PREADY after 2 waits, M_PRDATA=0xA5A5_0001 → S_PRDATA=0xA5A5_0001, PSLVERR=0, 3 access cycles.
- TIMEOUT_CYCLES=4, M_PREADY held 0 → S_PREADY=1 with PSLVERR=1 and PRDATA=0 on access cycle 5; M_PSEL=0 that cycle; ss_fault=1.
- After fault, write 0x1234 with ss_en=1 → blocked, M_PSEL never asserted, PSLVERR=1 after 1 access cycle; then ss_en=0 in IDLE → ss_fault=0.
- ss_en=0, write → M_PSEL stays 0, PREADY=1 and PSLVERR=1 in the first access cycle.
- reset_n low in access cycle 2 of a forwarded transfer → M_PSEL=0 that cycle, IDLE next cycle, ss_fault=0, counter=0.
- APB_GUARD_IRQ_EN defined, timeout run → irq_timeout rises the cycle after ss_fault and falls when ss_fault clears.
